// File: rtl/vx_barrier_ctrl.sv
// vx_barrier_ctrl: per-core barrier controller. Warps arrive over a
// valid/ready port, stall until the declared warp count is met, then
// the barrier releases all of its warps with a one-cycle pulse.
// Ports: clk, reset (async, active-high), req_valid/req_ready with
// req_wid/req_bar_id/req_size_m1, flush, stall_mask, release_valid,
// release_bar_id, release_mask, release_timeout, busy.
// Optional watchdog release: define BARRIER_TIMEOUT_EN.
module vx_barrier_ctrl #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_BARRIERS   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int NW_W = $clog2(NUM_WARPS),
  localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_W-1:0]      req_wid,
  input  logic [NB_W-1:0]      req_bar_id,
  input  logic [NW_W-1:0]      req_size_m1,
  input  logic                 flush,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 release_valid,
  output logic [NB_W-1:0]      release_bar_id,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 release_timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EVAL, REL} state_t;

  state_t state, state_n;

  logic [NUM_WARPS-1:0] mask [NUM_BARRIERS];
  logic [NW_W-1:0]      lat_wid;
  logic [NW_W-1:0]      lat_size;
  logic [NB_W-1:0]      lat_bar;

  logic                 expire_pending;
  logic [NB_W-1:0]      exp_idx;

  logic [NUM_WARPS-1:0] wid_oh;
  logic [NUM_WARPS-1:0] eval_mask;
  logic [NW_W:0]        eval_cnt;
  logic                 hit;
  logic                 any_mask;

  // Arrival evaluation on the latched request.
  always_comb begin
    wid_oh = '0;
    wid_oh[lat_wid] = 1'b1;
    eval_mask = mask[lat_bar] | wid_oh;
    eval_cnt = '0;
    for (int i = 0; i < NUM_WARPS; i++)
      eval_cnt = eval_cnt + (NW_W+1)'(eval_mask[i]);
    hit = (eval_cnt == ({1'b0, lat_size} + (NW_W+1)'(1)));
    any_mask = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++)
      any_mask = any_mask | (|mask[b]);
  end

`ifdef BARRIER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt [NUM_BARRIERS];

  // Held at zero while empty, so the first arrival starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++)
        cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        if (flush || (mask[b] == '0))
          cnt[b] <= '0;
        else if (cnt[b] != CNT_MAX)
          cnt[b] <= cnt[b] + CNT_W'(1);
      end
    end
  end

  // Descending scan leaves the lowest expired index selected.
  always_comb begin
    expire_pending = 1'b0;
    exp_idx = '0;
    for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
      if ((mask[b] != '0) && (cnt[b] == CNT_MAX)) begin
        expire_pending = 1'b1;
        exp_idx = NB_W'(b);
      end
    end
  end
`else
  assign expire_pending = 1'b0;
  assign exp_idx = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (expire_pending) state_n = REL;
          else if (req_valid) state_n = EVAL;
        end
        EVAL:    state_n = hit ? REL : IDLE;
        REL:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE) && !flush && !expire_pending;
    busy = (state != IDLE) || any_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++)
        mask[b] <= '0;
      stall_mask      <= '0;
      release_valid   <= 1'b0;
      release_bar_id  <= '0;
      release_mask    <= '0;
      release_timeout <= 1'b0;
      lat_wid         <= '0;
      lat_bar         <= '0;
      lat_size        <= '0;
    end else if (flush) begin
      for (int b = 0; b < NUM_BARRIERS; b++)
        mask[b] <= '0;
      stall_mask      <= '0;
      release_valid   <= 1'b0;
      release_bar_id  <= '0;
      release_mask    <= '0;
      release_timeout <= 1'b0;
    end else begin
      release_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (expire_pending) begin
            release_valid   <= 1'b1;
            release_bar_id  <= exp_idx;
            release_mask    <= mask[exp_idx];
            release_timeout <= 1'b1;
          end else if (req_valid) begin
            lat_wid  <= req_wid;
            lat_bar  <= req_bar_id;
            lat_size <= req_size_m1;
          end
        end
        EVAL: begin
          mask[lat_bar] <= eval_mask;
          if (hit) begin
            release_valid   <= 1'b1;
            release_bar_id  <= lat_bar;
            release_mask    <= eval_mask;
            release_timeout <= 1'b0;
          end else begin
            stall_mask[lat_wid] <= 1'b1;
          end
        end
        REL: begin
          mask[release_bar_id] <= '0;
          stall_mask <= stall_mask & ~release_mask;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// tb_vx_barrier_ctrl: directed and randomized checks of vx_barrier_ctrl
// against a set-based barrier model kept in the bench.
module tb_vx_barrier_ctrl;

  localparam int NW = 4;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_wid = '0;
  logic [1:0] req_bar_id = '0;
  logic [1:0] req_size_m1 = '0;
  logic       flush = 1'b0;
  logic [3:0] stall_mask;
  logic       release_valid;
  logic [1:0] release_bar_id;
  logic [3:0] release_mask;
  logic       release_timeout;
  logic       busy;

  vx_barrier_ctrl #(
    .NUM_WARPS(NW),
    .NUM_BARRIERS(NB),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wid(req_wid),
    .req_bar_id(req_bar_id),
    .req_size_m1(req_size_m1),
    .flush(flush),
    .stall_mask(stall_mask),
    .release_valid(release_valid),
    .release_bar_id(release_bar_id),
    .release_mask(release_mask),
    .release_timeout(release_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: the set of warps that have arrived at each barrier.
  logic [3:0] m_arr [NB];
  logic [3:0] m_stall;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++) m_arr[b] = '0;
    m_stall = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_wait", 0, 1);
  endtask

  // Called at a negedge; returns at a negedge with the request retired.
  task automatic do_req(input int w, input int b, input int s);
    logic [3:0] nm;
    logic rel;
    wait_ready();
    nm = m_arr[b] | (4'b0001 << w);
    rel = ($countones(nm) == s + 1);
    req_valid = 1'b1;
    req_wid = 2'(w);
    req_bar_id = 2'(b);
    req_size_m1 = 2'(s);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("eval_ready", int'(req_ready), 0);
    chk("eval_busy", int'(busy), 1);
    chk("eval_stall", int'(stall_mask), int'(m_stall));
    @(negedge clk);
    chk("rel_valid", int'(release_valid), int'(rel));
    if (rel) begin
      chk("rel_bar", int'(release_bar_id), b);
      chk("rel_mask", int'(release_mask), int'(nm));
      chk("rel_to", int'(release_timeout), 0);
      chk("rel_ready", int'(req_ready), 0);
      m_arr[b] = '0;
      m_stall = m_stall & ~nm;
      @(negedge clk);
      chk("rel_done", int'(release_valid), 0);
    end else begin
      m_arr[b] = nm;
      m_stall = m_stall | (4'b0001 << w);
    end
    chk("stall", int'(stall_mask), int'(m_stall));
    chk("ready_back", int'(req_ready), 1);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    chk("flush_stall", int'(stall_mask), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_rv", int'(release_valid), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stall"}, int'(stall_mask), 0);
    chk({tag, "_rv"}, int'(release_valid), 0);
    chk({tag, "_rbar"}, int'(release_bar_id), 0);
    chk({tag, "_rmask"}, int'(release_mask), 0);
    chk({tag, "_rto"}, int'(release_timeout), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_ready", int'(req_ready), 1);

    // Four-warp barrier filled in order.
    do_req(0, 1, 3);
    do_req(1, 1, 3);
    do_req(2, 1, 3);
    do_req(3, 1, 3);

    // Single-warp barrier releases at once.
    do_req(2, 0, 0);

    // Duplicate arrival does not count twice.
    do_req(1, 0, 1);
    do_req(1, 0, 1);
    do_req(3, 0, 1);

    // Interleaved barriers.
    do_req(0, 0, 1);
    do_req(1, 2, 1);
    do_req(2, 0, 1);
    chk("b2_hold", int'(stall_mask), 'h2);

    // Flush while a request is in EVAL.
    wait_ready();
    req_valid = 1'b1;
    req_wid = 2'd0;
    req_bar_id = 2'd2;
    req_size_m1 = 2'd1;
    @(posedge clk);
    #1 flush = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_rv", int'(release_valid), 0);
    chk("fl_ready_hi", int'(req_ready), 0);
    flush = 1'b0;
    model_clear();
    chk_reset_vals("fl");
    @(negedge clk);
    chk("fl_rv2", int'(release_valid), 0);
    chk("fl_ready", int'(req_ready), 1);

    // Asynchronous reset with warps stalled.
    do_req(1, 1, 3);
    do_req(2, 1, 3);
    chk("pre_rst", int'(stall_mask), 'h6);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("arst_ready", int'(req_ready), 1);
    chk("arst_rv", int'(release_valid), 0);

    // Randomized arrivals; periodic flushes keep barriers short-lived.
    for (int i = 0; i < 48; i++) begin
      do_req($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
      if (i % 4 == 3) do_flush();
    end

`ifdef BARRIER_TIMEOUT_EN
    begin
      int n;
      do_flush();
      do_req(0, 3, 2);
      n = 0;
      while (req_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("to_wait", int'(n >= 15 && n <= 18), 1);
      req_valid = 1'b1;
      req_wid = 2'd1;
      req_bar_id = 2'd0;
      req_size_m1 = 2'd0;
      @(negedge clk);
      chk("to_rv", int'(release_valid), 1);
      chk("to_flag", int'(release_timeout), 1);
      chk("to_bar", int'(release_bar_id), 3);
      chk("to_mask", int'(release_mask), 1);
      chk("to_hold", int'(req_ready), 0);
      @(negedge clk);
      chk("to_stall", int'(stall_mask), 0);
      chk("to_ready", int'(req_ready), 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("to_next_rv", int'(release_valid), 1);
      chk("to_next_mask", int'(release_mask), 2);
      chk("to_next_flag", int'(release_timeout), 0);
      @(negedge clk);
      model_clear();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
